// File: rtl/sr_seq_pkg.sv
// Shared definitions for the SR command sequencer:
// command op codes and FSM state encoding.
package sr_seq_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Synchronous command FIFO with extra-MSB pointers;
// full/empty come from the wrap-bit compare.
module sr_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, wp_d;
    logic [AW:0]  rp_q, rp_d;
    logic         do_push;
    logic         do_pop;

    assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty_o = (wp_q == rp_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rp_q[AW-1:0]];

    // Next pointer values; pointers wrap naturally.
    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (do_push) wp_d = wp_q + PTR_ONE;
        if (do_pop)  rp_d = rp_q + PTR_ONE;
    end

    // Pointer registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns queued set/reset/toggle commands into exclusive
// s/r pulses for an sr_ff and checks its q afterwards.
module sr_cmd_sequencer
    import sr_seq_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    input  logic       q_fb,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          s_q, r_q;
    logic          done_q, err_q, exp_q;

    logic          full, empty;
    logic [1:0]    head_op;
    logic          gap_last, chk_last, pop;
    logic          drv_set, drv_rst, is_nop;

    sr_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .din_i   (cmd_op),
        .pop_i   (pop),
        .dout_o  (head_op),
        .full_o  (full),
        .empty_o (empty)
    );

    // A new command may be taken from IDLE, or from the final
    // quiet cycle so back-to-back commands lose no extra cycle.
    always_comb begin
        gap_last = (state_q == ST_GAP) && (cnt_q == '0);
        chk_last = (state_q == ST_CHECK) && (GAP_CYC == 0);
        pop      = !empty &&
                   ((state_q == ST_IDLE) || gap_last || chk_last);
        is_nop   = (head_op == OP_NOP);
        drv_set  = (head_op == OP_SET) ||
                   ((head_op == OP_TOGGLE) && !q_fb);
        drv_rst  = (head_op == OP_RESET) ||
                   ((head_op == OP_TOGGLE) && q_fb);
    end

    // Sequencer FSM with pulse/gap counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_DRIVE: begin
                    if (cnt_q == '0) begin
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_CHECK: begin
                    if (q_fb != exp_q) err_q <= 1'b1;
                    if (GAP_CYC == 0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_GAP;
                        cnt_q   <= CW'(GAP_CYC - 1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) state_q <= ST_IDLE;
                    else             cnt_q   <= cnt_q - CW'(1);
                end
                default: ;
            endcase
            if (pop && !is_nop) begin
                state_q <= ST_DRIVE;
                cnt_q   <= CW'(PULSE_CYC - 1);
                s_q     <= drv_set;
                r_q     <= drv_rst;
                exp_q   <= drv_set;
            end
        end
    end

    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cmd_ready = !full;
    assign busy      = (state_q != ST_IDLE) || !empty;

endmodule
